spi_slave_loopback_top: RTL and testbench

//  Board-level top for an SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames) in a loopback config.
//  SCK/MOSI/CS_n come in on gp pins and are synchronised to clk_25mhz.

---
 rtl/spi_slave_loopback_top.sv | 143 ++++++++++++++
 tb/tb_spi_slave_loopback_top.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/spi_slave_loopback_top.sv
// -----------------------------------------------------------------------------
// spi_slave_loopback_top
//   Board-level SPI slave in loopback. The SPI mode is mode 0 (CPOL=0,
//   CPHA=0), with MSB-first, 8-bit frames. Every received byte is shown on
//   led. It is also returned on MISO during the next frame, which can fall in
//   the same CS window or a later one. SCK, MOSI and CS_n are oversampled by
//   clk_25mhz through synchronisers. All logic runs in that single domain.
//
// Ports
//   clk_25mhz  in   1  system clock (the only clock)
//   btn        in   7  btn[0] = asynchronous active-low reset; btn[6:1] unused
//   gp         in   6  gp[0]=SCK, gp[1]=MOSI, gp[2]=CS_n; gp[5:3] unused
//   gn         out  6  gn[0]=MISO, gn[1]=RX data-valid pulse, gn[5:2]=0
//   led        out  8  last received byte
//
// Parameters
//   SYNC_STAGES    synchroniser depth on each SPI input (>= 2)
//   RESET_TX_BYTE  byte returned in the first frame after reset
//
// Build option
//   SPI_MISO_TRISTATE_EN : when defined, MISO floats (1'bz) while the
//   synchronised CS_n is high. Otherwise MISO is always driven.
// -----------------------------------------------------------------------------
module spi_slave_loopback_top #(
  parameter int unsigned     SYNC_STAGES   = 2,
  parameter logic [7:0]      RESET_TX_BYTE = 8'h00
) (
  input  logic       clk_25mhz,
  input  logic [6:0] btn,
  input  logic [5:0] gp,
  output logic [5:0] gn,
  output logic [7:0] led
);

  logic rst_n;
  assign rst_n = btn[0];

  // Unused pins are folded into one net so that they are not left dangling.
  logic unused_pins;
  assign unused_pins = ^{btn[6:1], gp[5:3]};

  // Input synchronisers. CS_n resets to its idle (high) level, so leaving
  // reset with CS_n already low still gives a clean falling edge.
  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, csn_sync_q;
  logic                   sck_prev_q, csn_prev_q;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sck_prev_q  <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  gp[0]};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], gp[1]};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0],  gp[2]};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, mosi_s, csn_s;
  logic sck_rise, sck_fall, cs_fall;
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~csn_s & csn_prev_q;

  // Shift engine state
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] led_q, led_d;
  logic       dv_q, dv_d;
  logic [7:0] rx_next;

  assign rx_next = {rx_sr_q[6:0], mosi_s};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    tx_byte_d = tx_byte_q;
    led_d     = led_q;
    dv_d      = 1'b0;
    if (csn_s) begin
      // Deselected. Any partial frame is dropped, and rx_sr simply holds.
      bit_cnt_d = 3'd0;
    end else if (cs_fall) begin
      bit_cnt_d = 3'd0;
      tx_sr_d   = tx_byte_q;
    end else if (sck_rise) begin
      rx_sr_d   = rx_next;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        // Frame complete. Reloading tx_sr here makes the next byte in the
        // same CS window start with this byte's MSB.
        led_d     = rx_next;
        tx_byte_d = rx_next;
        tx_sr_d   = rx_next;
        dv_d      = 1'b1;
      end
    end else if (sck_fall && bit_cnt_q != 3'd0) begin
      // No shift at bit_cnt 0, so that a freshly loaded MSB stays in place.
      tx_sr_d = {tx_sr_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 3'd0;
      rx_sr_q   <= 8'h00;
      tx_sr_q   <= RESET_TX_BYTE;
      tx_byte_q <= RESET_TX_BYTE;
      led_q     <= 8'h00;
      dv_q      <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      tx_byte_q <= tx_byte_d;
      led_q     <= led_d;
      dv_q      <= dv_d;
    end
  end

  // MISO comes straight from a register, so there is no combinational path
  // from gp to gn.
  logic miso_pin;
`ifdef SPI_MISO_TRISTATE_EN
  assign miso_pin = csn_s ? 1'bz : tx_sr_q[7];
`else
  assign miso_pin = tx_sr_q[7];
`endif

  assign gn  = {4'b0000, dv_q, miso_pin};
  assign led = led_q;

endmodule

// File: tb/tb_spi_slave_loopback_top.sv
`timescale 1ns/1ps
module tb_spi_slave_loopback_top;

  logic       clk_25mhz;
  logic [6:0] btn;
  logic [5:0] gp;
  logic [5:0] gn;
  logic [7:0] led;

  int n_cmp;
  int n_err;
  int dv_cycles;

  spi_slave_loopback_top #(
    .SYNC_STAGES  (2),
    .RESET_TX_BYTE(8'h00)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .btn      (btn),
    .gp       (gp),
    .gn       (gn),
    .led      (led)
  );

  initial begin
    clk_25mhz = 1'b0;
    forever #20 clk_25mhz = ~clk_25mhz;
  end

  // Counts clock cycles with the data-valid pin high. Each frame must add exactly 1.
  always @(posedge clk_25mhz) begin
    if (gn[1] === 1'b1) dv_cycles <= dv_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 master bit loop. MOSI is set in the low phase, and MISO is sampled at the SCK rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      gp[1] = tx[7-i];
      #400;
      gp[0] = 1'b1;
      rx[7-i] = gn[0];
      #400;
      gp[0] = 1'b0;
    end
  endtask

  task automatic cs_low();
    gp[2] = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #200;
    gp[2] = 1'b1;
    #400;
  endtask

  logic [7:0] rx;
  int         dv0;

  initial begin
    n_cmp = 0;
    n_err = 0;
    dv_cycles = 0;
    btn = 7'h7E;            // btn[0] low -> reset asserted
    gp  = 6'b000100;        // CS_n high, SCK low
    @(negedge clk_25mhz);   // all later delays are multiples of 40 ns, away from posedge
    #200;
    check("rst_led",  {24'd0, led},  32'h00);
    check("rst_dv",   {31'd0, gn[1]}, 32'h0);
    check("rst_miso", {31'd0, gn[0]}, 32'h0);
    check("rst_gn_hi", {28'd0, gn[5:2]}, 32'h0);
    btn[0] = 1'b1;
    #400;

    // 1: first frame after reset
    dv0 = dv_cycles;
    cs_low(); spi_bits(8'hC1, 8, rx); cs_high();
    check("t1_miso", {24'd0, rx},  32'h00);
    check("t1_led",  {24'd0, led}, 32'hC1);
    check("t1_dv",   dv_cycles - dv0, 32'd1);

    // 2: two separate frames
    cs_low(); spi_bits(8'hBE, 8, rx); cs_high();
    check("t2_miso_a", {24'd0, rx},  32'hC1);
    check("t2_led_a",  {24'd0, led}, 32'hBE);
    dv0 = dv_cycles;
    cs_low(); spi_bits(8'hEF, 8, rx); cs_high();
    check("t2_miso_b", {24'd0, rx},  32'hBE);
    check("t2_led_b",  {24'd0, led}, 32'hEF);
    check("t2_dv",     dv_cycles - dv0, 32'd1);

    // 3: two bytes in one CS window
    dv0 = dv_cycles;
    cs_low();
    spi_bits(8'hA1, 8, rx);
    check("t3_miso_a", {24'd0, rx}, 32'hEF);
    check("t3_led_mid", {24'd0, led}, 32'hA1);
    spi_bits(8'h5C, 8, rx);
    check("t3_miso_b", {24'd0, rx}, 32'hA1);
    cs_high();
    check("t3_dv",  dv_cycles - dv0, 32'd2);
    check("t3_led", {24'd0, led}, 32'h5C);

    // 4: two more bytes in one CS window
    cs_low();
    spi_bits(8'h25, 8, rx);
    check("t4_miso_a", {24'd0, rx}, 32'h5C);
    spi_bits(8'h38, 8, rx);
    check("t4_miso_b", {24'd0, rx}, 32'h25);
    cs_high();
    check("t4_led", {24'd0, led}, 32'h38);

    // 5: reset mid-frame
    cs_low();
    spi_bits(8'h77, 4, rx);
    btn[0] = 1'b0;
    #200;
    check("t5_led_rst", {24'd0, led}, 32'h00);
    btn[0] = 1'b1;
    #200;
    cs_high();
    dv0 = dv_cycles;
    cs_low(); spi_bits(8'h12, 8, rx); cs_high();
    check("t5_miso", {24'd0, rx},  32'h00);
    check("t5_led",  {24'd0, led}, 32'h12);
    check("t5_dv",   dv_cycles - dv0, 32'd1);

    // 6: aborted frame, then a full frame
    dv0 = dv_cycles;
    cs_low(); spi_bits(8'h9A, 5, rx); cs_high();
    check("t6_abort_dv",  dv_cycles - dv0, 32'd0);
    check("t6_abort_led", {24'd0, led}, 32'h12);
    cs_low(); spi_bits(8'h9A, 8, rx); cs_high();
    check("t6_miso", {24'd0, rx},  32'h12);
    check("t6_led",  {24'd0, led}, 32'h9A);
    check("t6_dv",   dv_cycles - dv0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
